// File: rtl/ace_snoop_responder_pkg.sv
// Shared types for the ACE snoop responder: channel structs, snoop opcodes,
// CR response bit positions and the responder FSM state encoding.
package ace_snoop_responder_pkg;

    localparam int AC_ADDR_W = 64;
    localparam int CD_DATA_W = 64;

    typedef struct packed {
        logic [AC_ADDR_W-1:0] addr;
        logic [3:0]           snoop;
        logic [2:0]           prot;
    } ace_snoop_ac_t;

    typedef struct packed {
        logic [4:0] resp;
    } ace_snoop_cr_t;

    typedef struct packed {
        logic [CD_DATA_W-1:0] data;
        logic                 last;
    } ace_snoop_cd_t;

    typedef enum logic [3:0] {
        SNP_READ_ONCE      = 4'b0000,
        SNP_READ_SHARED    = 4'b0001,
        SNP_READ_CLEAN     = 4'b0010,
        SNP_READ_NSD       = 4'b0011,
        SNP_READ_UNIQUE    = 4'b0111,
        SNP_CLEAN_SHARED   = 4'b1000,
        SNP_CLEAN_INVALID  = 4'b1001,
        SNP_MAKE_INVALID   = 4'b1101
    } snoop_op_e;

    localparam int CR_DT = 0;   // DataTransfer
    localparam int CR_ERR = 1;  // Error
    localparam int CR_PD = 2;   // PassDirty
    localparam int CR_IS = 3;   // IsShared
    localparam int CR_WU = 4;   // WasUnique, never set by this responder

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WAIT_RES,
        ST_UPDATE,
        ST_SEND_CR,
        ST_SEND_CD
    } state_e;

endpackage

// File: rtl/ace_snoop_responder_decision.sv
// Snoop decision table: maps (snoop opcode, hit, dirty) to the CR response
// and to the line-state change the cache must apply. Purely combinational.
module ace_snoop_decision
    import ace_snoop_responder_pkg::*;
(
    input  logic [3:0] snoop,
    input  logic       hit,
    input  logic       dirty,
    output logic [4:0] resp,
    output logic       upd_needed,
    output logic       upd_inval,
    output logic       upd_clean,
    output logic       needs_lookup
);

    // Opcode decode; a miss on any supported opcode leaves everything at zero.
    always_comb begin
        resp         = '0;
        upd_needed   = 1'b0;
        upd_inval    = 1'b0;
        upd_clean    = 1'b0;
        needs_lookup = 1'b1;
        case (snoop)
            SNP_READ_ONCE, SNP_READ_CLEAN: begin
                if (hit) begin
                    resp[CR_DT] = 1'b1;
                    resp[CR_IS] = 1'b1;
                end
            end
            SNP_READ_SHARED, SNP_READ_NSD: begin
                if (hit) begin
                    resp[CR_DT] = 1'b1;
                    resp[CR_IS] = 1'b1;
                    resp[CR_PD] = dirty;
                    upd_needed  = dirty;
                    upd_clean   = dirty;
                end
            end
            SNP_READ_UNIQUE: begin
                if (hit) begin
                    resp[CR_DT] = 1'b1;
                    resp[CR_PD] = dirty;
                    upd_needed  = 1'b1;
                    upd_inval   = 1'b1;
                end
            end
            SNP_CLEAN_SHARED: begin
                if (hit) begin
                    resp[CR_DT] = dirty;
                    resp[CR_PD] = dirty;
                    resp[CR_IS] = 1'b1;
                    upd_needed  = dirty;
                    upd_clean   = dirty;
                end
            end
            SNP_CLEAN_INVALID: begin
                if (hit) begin
                    resp[CR_DT] = dirty;
                    resp[CR_PD] = dirty;
                    upd_needed  = 1'b1;
                    upd_inval   = 1'b1;
                end
            end
            SNP_MAKE_INVALID: begin
                if (hit) begin
                    upd_needed = 1'b1;
                    upd_inval  = 1'b1;
                end
            end
            default: begin
                resp[CR_ERR] = 1'b1;
                needs_lookup = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ace_snoop_responder.sv
// Cache-side ACE snoop responder: accepts one AC snoop, looks the line up,
// applies the line-state change, returns CR and streams the line on CD.
// Build option ACE_SNOOP_CWF_EN: when defined, CD starts at the beat holding
// the snooped address and wraps; otherwise CD always starts at beat 0.
//
// state       | meaning
// ------------+-------------------------------------------------------
// ST_IDLE     | ready for a snoop; only state with ac_ready_o high
// ST_LOOKUP   | lookup request held until the cache grants it
// ST_WAIT_RES | waiting for the lookup result; line data captured here
// ST_UPDATE   | line-state update held until the cache accepts it
// ST_SEND_CR  | snoop response held until cr_ready_i
// ST_SEND_CD  | streaming DcacheLineWords beats back to back
module ace_snoop_responder
    import ace_snoop_responder_pkg::*;
#(
    parameter int  DcacheLineWidth = 128,
    parameter int  AxiDataWidth    = 64,
    parameter int  AxiAddrWidth    = 64,
    parameter type snoop_ac_t      = ace_snoop_responder_pkg::ace_snoop_ac_t,
    parameter type snoop_cr_t      = ace_snoop_responder_pkg::ace_snoop_cr_t,
    parameter type snoop_cd_t      = ace_snoop_responder_pkg::ace_snoop_cd_t
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       ac_valid_i,
    output logic                       ac_ready_o,
    input  snoop_ac_t                  ac_i,
    output logic                       cr_valid_o,
    input  logic                       cr_ready_i,
    output snoop_cr_t                  cr_o,
    output logic                       cd_valid_o,
    input  logic                       cd_ready_i,
    output snoop_cd_t                  cd_o,
    output logic                       lookup_req_o,
    output logic [AxiAddrWidth-1:0]    lookup_addr_o,
    input  logic                       lookup_gnt_i,
    input  logic                       lookup_valid_i,
    input  logic                       lookup_hit_i,
    input  logic                       lookup_dirty_i,
    input  logic [DcacheLineWidth-1:0] lookup_data_i,
    output logic                       upd_valid_o,
    input  logic                       upd_ready_i,
    output logic                       upd_inval_o,
    output logic                       upd_clean_o
);

    localparam int DcacheLineWords = DcacheLineWidth / AxiDataWidth;
    localparam int LineOffW        = $clog2(DcacheLineWidth / 8);
    localparam int BeatOffW        = $clog2(AxiDataWidth / 8);
    localparam int BeatCntW        = $clog2(DcacheLineWords);

    state_e                     state_q, state_d;
    logic [AxiAddrWidth-1:0]    addr_q;
    logic [3:0]                 snoop_q;
    logic [4:0]                 resp_q;
    logic                       upd_inval_q, upd_clean_q;
    logic [DcacheLineWidth-1:0] line_q;
    logic [BeatCntW-1:0]        beat_cnt_q, start_beat_q, beat_idx;
    logic                       last_beat;

    logic [3:0] dec_snoop;
    logic [4:0] dec_resp;
    logic       dec_upd_needed, dec_upd_inval, dec_upd_clean, dec_needs_lookup;

    // In IDLE the incoming opcode decides whether a lookup is needed at all;
    // afterwards the latched opcode is combined with the lookup result.
    assign dec_snoop = (state_q == ST_IDLE) ? ac_i.snoop : snoop_q;

    ace_snoop_decision u_decision (
        .snoop        (dec_snoop),
        .hit          (lookup_hit_i),
        .dirty        (lookup_dirty_i),
        .resp         (dec_resp),
        .upd_needed   (dec_upd_needed),
        .upd_inval    (dec_upd_inval),
        .upd_clean    (dec_upd_clean),
        .needs_lookup (dec_needs_lookup)
    );

    assign beat_idx  = start_beat_q + beat_cnt_q;
    assign last_beat = (beat_cnt_q == BeatCntW'(DcacheLineWords - 1));

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d      = state_q;
        ac_ready_o   = 1'b0;
        lookup_req_o = 1'b0;
        upd_valid_o  = 1'b0;
        cr_valid_o   = 1'b0;
        cd_valid_o   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ac_ready_o = 1'b1;
                if (ac_valid_i) begin
                    state_d = dec_needs_lookup ? ST_LOOKUP : ST_SEND_CR;
                end
            end
            ST_LOOKUP: begin
                lookup_req_o = 1'b1;
                if (lookup_gnt_i) state_d = ST_WAIT_RES;
            end
            ST_WAIT_RES: begin
                if (lookup_valid_i) begin
                    state_d = dec_upd_needed ? ST_UPDATE : ST_SEND_CR;
                end
            end
            ST_UPDATE: begin
                upd_valid_o = 1'b1;
                if (upd_ready_i) state_d = ST_SEND_CR;
            end
            ST_SEND_CR: begin
                cr_valid_o = 1'b1;
                if (cr_ready_i) state_d = resp_q[CR_DT] ? ST_SEND_CD : ST_IDLE;
            end
            ST_SEND_CD: begin
                cd_valid_o = 1'b1;
                if (cd_ready_i && last_beat) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Transaction datapath: snoop capture, decision/line capture, beat counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q       <= '0;
            snoop_q      <= '0;
            resp_q       <= '0;
            upd_inval_q  <= 1'b0;
            upd_clean_q  <= 1'b0;
            line_q       <= '0;
            beat_cnt_q   <= '0;
            start_beat_q <= '0;
        end else begin
            if (state_q == ST_IDLE && ac_valid_i) begin
                addr_q      <= ac_i.addr;
                snoop_q     <= ac_i.snoop;
                resp_q      <= dec_resp;
                upd_inval_q <= 1'b0;
                upd_clean_q <= 1'b0;
                beat_cnt_q  <= '0;
`ifdef ACE_SNOOP_CWF_EN
                start_beat_q <= ac_i.addr[LineOffW-1:BeatOffW];
`else
                start_beat_q <= '0;
`endif
            end
            if (state_q == ST_WAIT_RES && lookup_valid_i) begin
                resp_q      <= dec_resp;
                upd_inval_q <= dec_upd_inval;
                upd_clean_q <= dec_upd_clean;
                line_q      <= lookup_data_i;
            end
            if (state_q == ST_SEND_CD && cd_ready_i) begin
                beat_cnt_q <= beat_cnt_q + 1'b1;
            end
        end
    end

    assign lookup_addr_o = {addr_q[AxiAddrWidth-1:LineOffW], {LineOffW{1'b0}}};
    assign upd_inval_o   = upd_inval_q;
    assign upd_clean_o   = upd_clean_q;

    // Response and data beat are driven from registers so they hold while stalled.
    always_comb begin
        cr_o      = '0;
        cr_o.resp = resp_q;
        cd_o      = '0;
        cd_o.data = line_q[int'(beat_idx) * AxiDataWidth +: AxiDataWidth];
        cd_o.last = last_beat;
    end

    // Protection bits and in-line offset play no part in the response.
    logic unused_bits;
    assign unused_bits = ^{ac_i.prot, addr_q[LineOffW-1:0]};

endmodule

// File: tb/tb_ace_snoop_responder.sv
module tb_ace_snoop_responder;
    import ace_snoop_responder_pkg::*;

    localparam int LINE_W = 128;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 64;
    localparam int WORDS  = LINE_W / DATA_W;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              ac_valid_i = 1'b0;
    logic              ac_ready_o;
    ace_snoop_ac_t     ac_i = '0;
    logic              cr_valid_o;
    logic              cr_ready_i = 1'b0;
    ace_snoop_cr_t     cr_o;
    logic              cd_valid_o;
    logic              cd_ready_i = 1'b0;
    ace_snoop_cd_t     cd_o;
    logic              lookup_req_o;
    logic [ADDR_W-1:0] lookup_addr_o;
    logic              lookup_gnt_i = 1'b0;
    logic              lookup_valid_i = 1'b0;
    logic              lookup_hit_i = 1'b0;
    logic              lookup_dirty_i = 1'b0;
    logic [LINE_W-1:0] lookup_data_i = '0;
    logic              upd_valid_o;
    logic              upd_ready_i = 1'b0;
    logic              upd_inval_o;
    logic              upd_clean_o;

    always #5 clk_i = ~clk_i;

    ace_snoop_responder dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .ac_valid_i     (ac_valid_i),
        .ac_ready_o     (ac_ready_o),
        .ac_i           (ac_i),
        .cr_valid_o     (cr_valid_o),
        .cr_ready_i     (cr_ready_i),
        .cr_o           (cr_o),
        .cd_valid_o     (cd_valid_o),
        .cd_ready_i     (cd_ready_i),
        .cd_o           (cd_o),
        .lookup_req_o   (lookup_req_o),
        .lookup_addr_o  (lookup_addr_o),
        .lookup_gnt_i   (lookup_gnt_i),
        .lookup_valid_i (lookup_valid_i),
        .lookup_hit_i   (lookup_hit_i),
        .lookup_dirty_i (lookup_dirty_i),
        .lookup_data_i  (lookup_data_i),
        .upd_valid_o    (upd_valid_o),
        .upd_ready_i    (upd_ready_i),
        .upd_inval_o    (upd_inval_o),
        .upd_clean_o    (upd_clean_o)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic              hit;
        logic              dirty;
        logic [LINE_W-1:0] data;
    } cache_ent_t;

    cache_ent_t        cache_q[$];
    logic [ADDR_W-1:0] look_q[$];
    logic [1:0]        upd_q[$];
    logic [4:0]        cr_q[$];
    logic [DATA_W:0]   cd_q[$];

    int cd_hs_cnt = 0;
    int gnt_cnt   = 0;
    bit force_ready = 1'b0;

    task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model written from the opcode rule table.
    task automatic model(input logic [3:0] op, input logic hit, input logic dirty,
                         output logic [4:0] resp, output bit upd, output bit inval,
                         output bit clean, output bit lookup);
        bit supported, dt, pd, is_sh;
        supported = op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd8, 4'd9, 4'd13};
        resp = '0; upd = 0; inval = 0; clean = 0; lookup = supported;
        if (!supported) begin
            resp = 5'b00010;
        end else if (hit) begin
            dt    = (op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd7}) || ((op inside {4'd8, 4'd9}) && dirty);
            pd    = (op inside {4'd1, 4'd3, 4'd7, 4'd8, 4'd9}) && dirty;
            is_sh = op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd8};
            inval = op inside {4'd7, 4'd9, 4'd13};
            clean = dirty && (op inside {4'd1, 4'd3, 4'd8});
            upd   = inval || clean;
            resp  = {1'b0, is_sh, pd, 1'b0, dt};
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [ADDR_W-1:0] addr, input logic hit,
                         input logic dirty, input logic [LINE_W-1:0] data, input int cd_beats);
        logic [4:0] resp;
        bit upd, inval, clean, lookup, accepted;
        int start;
        cache_ent_t e;
        model(op, hit, dirty, resp, upd, inval, clean, lookup);
        if (lookup) begin
            e.hit = hit; e.dirty = dirty; e.data = data;
            cache_q.push_back(e);
            look_q.push_back(addr & ~64'hF);
        end
        if (upd) upd_q.push_back({inval, clean});
        cr_q.push_back(resp);
`ifdef ACE_SNOOP_CWF_EN
        start = int'((addr / (DATA_W / 8)) % WORDS);
`else
        start = 0;
`endif
        if (resp[0]) begin
            for (int k = 0; k < WORDS && k < cd_beats; k++) begin
                cd_q.push_back({data[((start + k) % WORDS) * DATA_W +: DATA_W], k == WORDS - 1});
            end
        end
        @(posedge clk_i); #1;
        ac_valid_i = 1'b1;
        ac_i.addr  = addr;
        ac_i.snoop = op;
        ac_i.prot  = 3'($urandom);
        accepted = 0;
        for (int c = 0; c < 1000 && !accepted; c++) begin
            @(negedge clk_i);
            accepted = ac_ready_o;
            @(posedge clk_i); #1;
        end
        if (!accepted) check("ac_timeout", 0, 1);
        ac_valid_i = 1'b0;
        ac_i.snoop = 4'($urandom);
    endtask

    task automatic drain();
        bit done = 0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk_i);
            done = (cache_q.size() == 0) && (look_q.size() == 0) && (upd_q.size() == 0) &&
                   (cr_q.size() == 0) && (cd_q.size() == 0) && ac_ready_o;
        end
        if (!done) check("drain_timeout", 0, 1);
    endtask

    // Random ready/grant driver, changed just after each rising edge.
    initial begin
        forever begin
            @(posedge clk_i); #1;
            lookup_gnt_i = force_ready ? 1'b1 : 1'($urandom);
            upd_ready_i  = force_ready ? 1'b1 : ($urandom_range(0, 2) == 0);
            cr_ready_i   = force_ready ? 1'b1 : 1'($urandom);
            cd_ready_i   = force_ready ? 1'b1 : 1'($urandom);
        end
    end

    // Cache model: answers each granted lookup 1..3 cycles later, then scrambles its outputs.
    initial begin
        bit pending = 0;
        int dly = 0;
        int served = 0;
        cache_ent_t e;
        forever begin
            @(posedge clk_i); #1;
            lookup_valid_i = 1'b0;
            lookup_hit_i   = 1'($urandom);
            lookup_dirty_i = 1'($urandom);
            lookup_data_i  = {$urandom, $urandom, $urandom, $urandom};
            if (!rst_ni) begin
                pending = 0;
                served  = gnt_cnt;
            end else begin
                if (pending) begin
                    if (dly == 0) begin
                        lookup_valid_i = 1'b1;
                        lookup_hit_i   = e.hit;
                        lookup_dirty_i = e.dirty;
                        lookup_data_i  = e.data;
                        pending = 0;
                    end else begin
                        dly--;
                    end
                end
                if (served != gnt_cnt) begin
                    served = gnt_cnt;
                    if (cache_q.size() > 0) begin
                        e = cache_q.pop_front();
                        pending = 1;
                        dly = $urandom_range(0, 2);
                    end
                end
            end
        end
    end

    // Monitor: pops the scoreboard on each handshake and checks stability under stall.
    initial begin
        bit cr_p = 0, cd_p = 0, up_p = 0;
        logic [4:0] cr_v;
        logic [DATA_W:0] cd_v;
        logic [1:0] up_v;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                cr_p = 0; cd_p = 0; up_p = 0;
            end else begin
                if (lookup_req_o && lookup_gnt_i) begin
                    gnt_cnt++;
                    if (look_q.size() == 0) check("lookup_unexpected", 1, 0);
                    else check("lookup_addr", lookup_addr_o, look_q.pop_front());
                end
                if (upd_valid_o) begin
                    if (up_p) check("upd_stable", {upd_inval_o, upd_clean_o}, up_v);
                    if (upd_ready_i) begin
                        if (upd_q.size() == 0) check("upd_unexpected", 1, 0);
                        else check("upd_flags", {upd_inval_o, upd_clean_o}, upd_q.pop_front());
                        up_p = 0;
                    end else begin
                        up_p = 1; up_v = {upd_inval_o, upd_clean_o};
                    end
                end else begin
                    if (up_p) check("upd_dropped", 0, 1);
                    up_p = 0;
                end
                if (cr_valid_o) begin
                    if (cr_p) check("cr_stable", cr_o.resp, cr_v);
                    if (cr_ready_i) begin
                        if (cr_q.size() == 0) check("cr_unexpected", 1, 0);
                        else check("cr_resp", cr_o.resp, cr_q.pop_front());
                        cr_p = 0;
                    end else begin
                        cr_p = 1; cr_v = cr_o.resp;
                    end
                end else begin
                    if (cr_p) check("cr_dropped", 0, 1);
                    cr_p = 0;
                end
                if (cd_valid_o) begin
                    if (cd_p) check("cd_stable", {cd_o.data, cd_o.last}, cd_v);
                    if (cd_ready_i) begin
                        cd_hs_cnt++;
                        if (cd_q.size() == 0) check("cd_unexpected", 1, 0);
                        else check("cd_beat", {cd_o.data, cd_o.last}, cd_q.pop_front());
                        cd_p = 0;
                    end else begin
                        cd_p = 1; cd_v = {cd_o.data, cd_o.last};
                    end
                end else begin
                    if (cd_p) check("cd_dropped", 0, 1);
                    cd_p = 0;
                end
            end
        end
    end

    // Stimulus: reset check, directed cases, random traffic, mid-burst reset.
    initial begin
        int base;
        bit seen;
        logic [3:0] ops[8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd8, 4'd9, 4'd13};
        logic [3:0] op;

        repeat (2) @(negedge clk_i);
        check("rst_ac_ready", ac_ready_o, 1);
        check("rst_cr_valid", cr_valid_o, 0);
        check("rst_cd_valid", cd_valid_o, 0);
        check("rst_lookup_req", lookup_req_o, 0);
        check("rst_upd_valid", upd_valid_o, 0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        force_ready = 1'b1;
        issue(4'b0001, 64'h1000, 1, 1, {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222}, WORDS);
        drain();
        force_ready = 1'b0;
        issue(4'b0111, 64'h2040, 1, 0, {64'hAAAA_0000_BBBB_0001, 64'hCCCC_0000_DDDD_0002}, WORDS);
        issue(4'b1101, 64'h3000, 1, 1, {$urandom, $urandom, $urandom, $urandom}, WORDS);
        issue(4'b1001, 64'h4010, 0, 1, {$urandom, $urandom, $urandom, $urandom}, WORDS);
        issue(4'b1111, 64'h5000, 1, 1, {$urandom, $urandom, $urandom, $urandom}, WORDS);
        issue(4'b0000, 64'h6008, 1, 0, {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210}, WORDS);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 4) == 0) op = 4'($urandom);
            else op = ops[$urandom_range(0, 7)];
            issue(op, {$urandom, $urandom}, 1'($urandom), 1'($urandom),
                  {$urandom, $urandom, $urandom, $urandom}, WORDS);
            repeat ($urandom_range(0, 2)) @(posedge clk_i);
        end
        drain();

        base = cd_hs_cnt;
        issue(4'b0000, 64'h7000, 1, 0, {64'h5555_6666_7777_8888, 64'h9999_AAAA_BBBB_CCCC}, 1);
        seen = 0;
        for (int c = 0; c < 1000 && !seen; c++) begin
            @(posedge clk_i); #1;
            seen = (cd_hs_cnt > base);
        end
        if (!seen) check("rst_mid_timeout", 0, 1);
        rst_ni = 1'b0;
        #1;
        check("midrst_cd_valid", cd_valid_o, 0);
        check("midrst_cr_valid", cr_valid_o, 0);
        check("midrst_lookup_req", lookup_req_o, 0);
        check("midrst_upd_valid", upd_valid_o, 0);
        cache_q.delete(); look_q.delete(); upd_q.delete(); cr_q.delete(); cd_q.delete();
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("postrst_ac_ready", ac_ready_o, 1);
        repeat (20) begin
            @(negedge clk_i);
            check("postrst_no_cd", cd_valid_o, 0);
        end

        issue(4'b0011, 64'h8008, 1, 1, {$urandom, $urandom, $urandom, $urandom}, WORDS);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
